usr_burst: RTL

//  Parametrised universal shift register with a command/handshake front end.

---
 rtl/usr_pkg.sv | 66 ++++++
 rtl/usr_shift_step.sv | 22 ++
 rtl/usr_burst.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Package for the usr_burst universal shift register.
// Holds the operation codes, the burst FSM state encoding and the
// single-step next-value function shared by the datapath.
// Optional feature macro used by this slice: USR_ABORT_EN (burst abort port).
package usr_pkg;

    // Widest register the step function supports; narrower users zero-extend.
    localparam int USR_MAX_W = 64;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Shift-class ops are the ones that run as a counted burst.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // One step of the register for an arbitrary width <= USR_MAX_W.
    // Bits above 'width' are always returned as zero.
    function automatic logic [USR_MAX_W-1:0] step_value(
        input logic [USR_MAX_W-1:0] q,
        input int                   width,
        input logic [2:0]           op,
        input logic                 ser_left_in,
        input logic                 ser_right_in,
        input logic [USR_MAX_W-1:0] data_in
    );
        logic [USR_MAX_W-1:0] mask;
        logic [USR_MAX_W-1:0] msb;
        logic [USR_MAX_W-1:0] r;
        int                   top;
        top  = width - 1;
        // Shifting by the full width yields zero, so width==USR_MAX_W gives all ones.
        mask = (USR_MAX_W'(1'b1) << width) - USR_MAX_W'(1'b1);
        msb  = (q >> top) & USR_MAX_W'(1'b1);
        case (op)
            OP_NOP:   r = q;
            OP_SHR:   r = (q >> 1'b1) | (USR_MAX_W'(ser_right_in) << top);
            OP_SHL:   r = (q << 1'b1) | USR_MAX_W'(ser_left_in);
            OP_LOAD:  r = data_in;
            OP_ROR:   r = (q >> 1'b1) | (USR_MAX_W'(q[0]) << top);
            OP_ROL:   r = (q << 1'b1) | msb;
            OP_ASR:   r = (q >> 1'b1) | (msb << top);
            OP_CLEAR: r = {USR_MAX_W{1'b0}};
            default:  r = q;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step next value of the universal shift register.
// WIDTH must not exceed usr_pkg::USR_MAX_W.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             ser_left_in,
    input  logic             ser_right_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q_next
);

    // Evaluate one step at full package width and keep the low WIDTH bits.
    always_comb begin
        q_next = WIDTH'(step_value(USR_MAX_W'(q), WIDTH, op, ser_left_in,
                                   ser_right_in, USR_MAX_W'(data_in)));
    end

endmodule

// File: rtl/usr_burst.sv
// usr_burst: universal shift register with a valid/ready command front end.
// Immediate ops (NOP/LOAD/CLEAR, or a shift with count 0) complete at the
// accepting edge; shift-class ops with count N run N autonomous steps.
// Optional feature macro: USR_ABORT_EN adds abort/aborted to cut a burst short.
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_left_in,
    input  logic             ser_right_in,
`ifdef USR_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] parallel_data,
    output logic             ser_left_out,
    output logic             ser_right_out,
    output logic             busy,
    output logic             done
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] rem_nxt_s;
    logic [2:0]       op_r;
    logic [2:0]       op_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic [2:0]       step_op_s;
    logic [WIDTH-1:0] q_step_s;
    logic             accept_s;
`ifdef USR_ABORT_EN
    logic             aborted_r;
    logic             aborted_nxt_s;
`endif

    assign accept_s = cmd_valid && (state_r == ST_IDLE);

    // Pick the op the step unit evaluates: latched op while bursting,
    // otherwise the offered op, with shift-class count-0 commands as no change.
    always_comb begin
        step_op_s = OP_NOP;
        if (state_r == ST_SHIFT) begin
            step_op_s = op_r;
        end else if (is_shift_op(cmd_op)) begin
            step_op_s = OP_NOP;
        end else begin
            step_op_s = cmd_op;
        end
    end

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q            (q_r),
        .op           (step_op_s),
        .ser_left_in  (ser_left_in),
        .ser_right_in (ser_right_in),
        .data_in      (data_in),
        .q_next       (q_step_s)
    );

    // Burst FSM: next state, remaining-step counter, register value and pulses.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        op_nxt_s    = op_r;
        q_nxt_s     = q_r;
        done_nxt_s  = 1'b0;
`ifdef USR_ABORT_EN
        aborted_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_shift_op(cmd_op) && (cmd_count != {CNT_W{1'b0}})) begin
                        // Data is untouched at the accept edge; steps start next edge.
                        op_nxt_s    = cmd_op;
                        rem_nxt_s   = cmd_count;
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        q_nxt_s    = q_step_s;
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    q_nxt_s = q_r;
                end
            end
            ST_SHIFT: begin
`ifdef USR_ABORT_EN
                if (abort) begin
                    // Abort beats the step, including the final one.
                    state_nxt_s   = ST_IDLE;
                    rem_nxt_s     = {CNT_W{1'b0}};
                    aborted_nxt_s = 1'b1;
                end else begin
`endif
                    q_nxt_s   = q_step_s;
                    rem_nxt_s = rem_r - CNT_W'(1'b1);
                    if (rem_r == CNT_W'(1'b1)) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
`ifdef USR_ABORT_EN
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
                rem_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, data register and completion pulses; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            rem_r   <= {CNT_W{1'b0}};
            op_r    <= OP_NOP;
            q_r     <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
`ifdef USR_ABORT_EN
            aborted_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            op_r    <= op_nxt_s;
            q_r     <= q_nxt_s;
            done_r  <= done_nxt_s;
`ifdef USR_ABORT_EN
            aborted_r <= aborted_nxt_s;
`endif
        end
    end

    assign cmd_ready     = (state_r == ST_IDLE);
    assign busy          = (state_r == ST_SHIFT);
    assign done          = done_r;
    assign parallel_data = q_r;
    assign ser_left_out  = q_r[WIDTH-1];
    assign ser_right_out = q_r[0];
`ifdef USR_ABORT_EN
    assign aborted = aborted_r;
`endif

endmodule
